// File: rtl/rx_sr_pkg.sv
// Shared definitions for the UART receive shift register: idle fill level,
// frame-length helper and the per-frame error flag bundle.
package rx_sr_pkg;

  localparam logic RX_IDLE_LEVEL = 1'b1;

  typedef struct packed {
    logic parity;
    logic framing;
  } rx_err_t;

  function automatic int frame_bits(input int data_bits, input int parity_en);
    return data_bits + parity_en + 1;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Rollover bit counter: counts enables, wraps to 0 after rollover_val and
// raises rollover_flag for one cycle on the wrapping edge; clear wins over count.
module rx_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
        flag_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/rx_frame_sr.sv
// UART receive shift register: LSB-first capture of data, optional parity and stop bit.
// All outputs are registered and update on the shifting edge; clear restarts the frame.
module rx_frame_sr
  import rx_sr_pkg::*;
#(
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY_EN  = 0,
  parameter  int PARITY_ODD = 0,
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN),
  localparam int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 parity_bit,
  output logic                 stop_bit,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam logic             PAR_EN   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  rx_err_t               err_q, err_d;
  logic                  last_bit;

  assign last_bit = shift_strobe && (bit_count == LAST_CNT);

  // Errors are judged on the post-shift frame, so they read sr_d rather than sr_q.
  always_comb begin
    sr_d  = sr_q;
    err_d = err_q;
    if (clear) begin
      sr_d  = {FRAME_BITS{RX_IDLE_LEVEL}};
      err_d = '0;
    end else if (shift_strobe) begin
      sr_d = {serial_in, sr_q[FRAME_BITS-1:1]};
      if (last_bit) begin
        err_d.framing = ~serial_in;
        err_d.parity  = PAR_EN & ((^sr_d[DATA_BITS+PARITY_EN-1:0]) != PAR_ODD);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q  <= {FRAME_BITS{RX_IDLE_LEVEL}};
      err_q <= '0;
    end else begin
      sr_q  <= sr_d;
      err_q <= err_d;
    end
  end

  rx_bit_counter #(
    .WIDTH(CNT_W)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (shift_strobe),
    .rollover_val (LAST_CNT),
    .count_out    (bit_count),
    .rollover_flag(frame_done)
  );

  if (PARITY_EN != 0) begin : g_parity
    assign parity_bit = sr_q[DATA_BITS];
  end else begin : g_no_parity
    assign parity_bit = RX_IDLE_LEVEL;
  end

  assign packet_data   = sr_q[DATA_BITS-1:0];
  assign stop_bit      = sr_q[FRAME_BITS-1];
  assign parity_error  = err_q.parity;
  assign framing_error = err_q.framing;

endmodule

// File: tb/tb_rx_frame_sr.sv
// Directed bench: three receivers (8N1, 7E1, 7O1) share one serial stream;
// all three use 9-bit frames, so one stimulus exercises every configuration.
module tb_rx_frame_sr;

  logic clk, n_rst, shift_strobe, serial_in, clear;

  logic [7:0] a_data;
  logic       a_par, a_stop, a_done, a_perr, a_ferr;
  logic [3:0] a_cnt;
  logic [6:0] b_data;
  logic       b_par, b_stop, b_done, b_perr, b_ferr;
  logic [3:0] b_cnt;
  logic [6:0] c_data;
  logic       c_par, c_stop, c_done, c_perr, c_ferr;
  logic [3:0] c_cnt;

  int errors = 0;
  int checks = 0;

  rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .serial_in(serial_in),
    .clear(clear), .packet_data(a_data), .parity_bit(a_par), .stop_bit(a_stop),
    .bit_count(a_cnt), .frame_done(a_done), .parity_error(a_perr), .framing_error(a_ferr));

  rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .serial_in(serial_in),
    .clear(clear), .packet_data(b_data), .parity_bit(b_par), .stop_bit(b_stop),
    .bit_count(b_cnt), .frame_done(b_done), .parity_error(b_perr), .framing_error(b_ferr));

  rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .serial_in(serial_in),
    .clear(clear), .packet_data(c_data), .parity_bit(c_par), .stop_bit(c_stop),
    .bit_count(c_cnt), .frame_done(c_done), .parity_error(c_perr), .framing_error(c_ferr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enter and leave at a falling edge; one strobe per cycle, bit i sent i-th.
  task automatic send_bits(input logic [8:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      shift_strobe = 1'b1;
      serial_in    = bits[i];
      @(negedge clk);
      shift_strobe = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; shift_strobe = 1'b0; serial_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_data !== 8'hFF) begin errors++; $display("FAIL rst_data: got %h want ff", a_data); end
    checks++; if (a_stop !== 1'b1) begin errors++; $display("FAIL rst_stop: got %b want 1", a_stop); end
    checks++; if (a_par !== 1'b1) begin errors++; $display("FAIL rst_par: got %b want 1", a_par); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", a_done); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", a_perr); end
    checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", a_ferr); end
    checks++; if (b_data !== 7'h7F) begin errors++; $display("FAIL rst_b_data: got %h want 7f", b_data); end
    checks++; if (b_par !== 1'b1) begin errors++; $display("FAIL rst_b_par: got %b want 1", b_par); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    send_bits(9'h155, 9);
    checks++; if (a_data !== 8'h55) begin errors++; $display("FAIL fr_data: got %h want 55", a_data); end
    checks++; if (a_stop !== 1'b1) begin errors++; $display("FAIL fr_stop: got %b want 1", a_stop); end
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL fr_done: got %b want 1", a_done); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL fr_cnt: got %0d want 0", a_cnt); end
    checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL fr_ferr: got %b want 0", a_ferr); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL fr_perr: got %b want 0", a_perr); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL fr_done_pulse: got %b want 0", a_done); end
    send_bits(9'h055, 9);
    checks++; if (a_stop !== 1'b0) begin errors++; $display("FAIL fr0_stop: got %b want 0", a_stop); end
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL fr0_done: got %b want 1", a_done); end
    checks++; if (a_ferr !== 1'b1) begin errors++; $display("FAIL fr0_ferr: got %b want 1", a_ferr); end
    repeat (3) @(negedge clk);
    checks++; if (a_ferr !== 1'b1) begin errors++; $display("FAIL fr0_ferr_hold: got %b want 1", a_ferr); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL fr0_done_idle: got %b want 0", a_done); end
  endtask

  // Same 0x55/stop=1 frame with 0..3 idle cycles between bits.
  task automatic test_gaps();
    logic [8:0] bits;
    bits = 9'h155;
    for (int i = 0; i < 9; i++) begin
      shift_strobe = 1'b1;
      serial_in    = bits[i];
      @(negedge clk);
      shift_strobe = 1'b0;
      if (i < 8) begin
        checks++; if (a_cnt !== 4'(i + 1)) begin errors++; $display("FAIL gap_cnt[%0d]: got %0d want %0d", i, a_cnt, i + 1); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL gap_done[%0d]: got %b want 0", i, a_done); end
        checks++; if (a_ferr !== 1'b1) begin errors++; $display("FAIL gap_ferr_mid[%0d]: got %b want 1", i, a_ferr); end
        for (int g = 0; g < (i % 4); g++) begin
          @(negedge clk);
          checks++; if (a_cnt !== 4'(i + 1)) begin errors++; $display("FAIL gap_hold[%0d]: got %0d want %0d", i, a_cnt, i + 1); end
        end
      end
    end
    checks++; if (a_data !== 8'h55) begin errors++; $display("FAIL gap_data: got %h want 55", a_data); end
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL gap_done_end: got %b want 1", a_done); end
    checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL gap_ferr: got %b want 0", a_ferr); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL gap_cnt_end: got %0d want 0", a_cnt); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL gap_done_pulse: got %b want 0", a_done); end
  endtask

  task automatic test_parity();
    // data 1010011 (four ones), parity 0, stop 1
    send_bits(9'h153, 9);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL par_b_done: got %b want 1", b_done); end
    checks++; if (b_data !== 7'h53) begin errors++; $display("FAIL par_b_data: got %h want 53", b_data); end
    checks++; if (b_par !== 1'b0) begin errors++; $display("FAIL par_b_pbit: got %b want 0", b_par); end
    checks++; if (b_stop !== 1'b1) begin errors++; $display("FAIL par_b_stop: got %b want 1", b_stop); end
    checks++; if (b_perr !== 1'b0) begin errors++; $display("FAIL par_even_ok: got %b want 0", b_perr); end
    checks++; if (c_perr !== 1'b1) begin errors++; $display("FAIL par_odd_bad: got %b want 1", c_perr); end
    checks++; if (b_ferr !== 1'b0) begin errors++; $display("FAIL par_b_ferr: got %b want 0", b_ferr); end
    checks++; if (a_data !== 8'h53) begin errors++; $display("FAIL par_a_data: got %h want 53", a_data); end
    @(negedge clk);
    // same data, parity 1
    send_bits(9'h1D3, 9);
    checks++; if (b_par !== 1'b1) begin errors++; $display("FAIL par1_b_pbit: got %b want 1", b_par); end
    checks++; if (b_perr !== 1'b1) begin errors++; $display("FAIL par1_even_bad: got %b want 1", b_perr); end
    checks++; if (c_perr !== 1'b0) begin errors++; $display("FAIL par1_odd_ok: got %b want 0", c_perr); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL par1_a_perr: got %b want 0", a_perr); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    send_bits(9'h055, 9);
    checks++; if (a_ferr !== 1'b1) begin errors++; $display("FAIL clr_pre_ferr: got %b want 1", a_ferr); end
    checks++; if (c_perr !== 1'b1) begin errors++; $display("FAIL clr_pre_cperr: got %b want 1", c_perr); end
    send_bits(9'h005, 4);
    checks++; if (a_cnt !== 4'd4) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 4", a_cnt); end
    clear = 1'b1; shift_strobe = 1'b1; serial_in = 1'b0;
    @(negedge clk);
    clear = 1'b0; shift_strobe = 1'b0;
    checks++; if (a_data !== 8'hFF) begin errors++; $display("FAIL clr_data: got %h want ff", a_data); end
    checks++; if (a_stop !== 1'b1) begin errors++; $display("FAIL clr_stop: got %b want 1", a_stop); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", a_cnt); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL clr_done: got %b want 0", a_done); end
    checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL clr_ferr: got %b want 0", a_ferr); end
    checks++; if (c_perr !== 1'b0) begin errors++; $display("FAIL clr_cperr: got %b want 0", c_perr); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL clr_done_late: got %b want 0", a_done); end
    send_bits(9'h155, 8);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL clr_done_early: got %b want 0", a_done); end
    send_bits(9'h100, 1);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL clr_next_done: got %b want 1", a_done); end
    checks++; if (a_data !== 8'h55) begin errors++; $display("FAIL clr_next_data: got %h want 55", a_data); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    send_bits(9'h00A, 5);
    checks++; if (a_cnt !== 4'd5) begin errors++; $display("FAIL ar_pre_cnt: got %0d want 5", a_cnt); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (a_data !== 8'hFF) begin errors++; $display("FAIL ar_data: got %h want ff", a_data); end
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL ar_cnt: got %0d want 0", a_cnt); end
    checks++; if (a_stop !== 1'b1) begin errors++; $display("FAIL ar_stop: got %b want 1", a_stop); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send_bits(9'h1AA, 9);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ar_next_done: got %b want 1", a_done); end
    checks++; if (a_data !== 8'hAA) begin errors++; $display("FAIL ar_next_data: got %h want aa", a_data); end
    checks++; if (a_ferr !== 1'b0) begin errors++; $display("FAIL ar_next_ferr: got %b want 0", a_ferr); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_parity();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_sr.md
Name: rx_frame_sr

Overview:
Parametrised UART receive shift register, the successor to the fixed 9-bit receiver shift register.
- Captures a serial frame LSB-first: configurable data bits, optional parity bit, then stop bit.
- Counts received bits and pulses frame_done when a full frame has been captured.
- Flags parity and framing errors.
- Sits between the receiver timer/edge-detect logic, which supplies shift_strobe, and the RX FIFO/control FSM.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..9.
- PARITY_EN, 0, 1 = a parity bit follows the data bits, 0 = no parity bit.
- PARITY_ODD, 0, with PARITY_EN=1: 1 = odd parity, 0 = even parity; ignored otherwise.
- Derived localparams (not overridable): FRAME_BITS = DATA_BITS + PARITY_EN + 1; CNT_W = $clog2(FRAME_BITS+1).

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- shift_strobe  input  1  one-cycle qualifier: sample serial_in this edge.
- serial_in  input  1  serial receive bit.
- clear  input  1  synchronous frame restart.
- packet_data  output  DATA_BITS  captured data, bit0 = first received bit.
- parity_bit  output  1  captured parity bit; constant 1 when PARITY_EN=0.
- stop_bit  output  1  captured stop bit (last bit received).
- bit_count  output  CNT_W  number of bits received in the current frame.
- frame_done  output  1  one-cycle pulse: frame complete.
- parity_error  output  1  sticky per frame.
- framing_error  output  1  sticky per frame; set when stop bit = 0.

Behaviour:
- Reset values (async, n_rst=0): shift register all ones, so packet_data = all ones, parity_bit = 1, stop_bit = 1; bit_count = 0; frame_done = 0; parity_error = 0; framing_error = 0.
- Register sr[FRAME_BITS-1:0]. On a strobe edge: sr <= {serial_in, sr[FRAME_BITS-1:1]} (right shift, new bit enters at the MSB).
- Output mapping: packet_data = sr[DATA_BITS-1:0]; parity_bit = sr[DATA_BITS] when PARITY_EN=1; stop_bit = sr[FRAME_BITS-1]. Outputs are driven directly from registers, so their latency is the shift edge itself.
- shift_strobe=0: sr and bit_count hold. Strobes may be arbitrarily non-contiguous.
- bit_count increments on each strobe. On the strobe where bit_count == FRAME_BITS-1 it wraps to 0, and the same edge sets frame_done=1 for exactly one cycle.
- Error evaluation at that same frame-completing edge uses the post-shift contents:
  - framing_error <= ~serial_in.
  - parity_error <= PARITY_EN & (^{data, parity} != PARITY_ODD).
- Error flags then hold until the next frame-completing edge or clear. They are never updated mid-frame.
- clear=1 (synchronous) takes priority over shift_strobe:
  - sr <= all ones; bit_count <= 0.
  - frame_done, parity_error and framing_error <= 0.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- A new frame begins on the first strobe after wrap, with no idle cycle required. frame_done may reassert FRAME_BITS strobes later, back-to-back frames being allowed.

Decomposition:
- Package rx_sr_pkg holds:
  - constant RX_IDLE_LEVEL = 1'b1 (reset fill value);
  - function frame_bits(data_bits, parity_en);
  - typedef rx_err_t struct {parity, framing}.
- One sub-module, rx_bit_counter: parametrised rollover counter with clear, count_enable, rollover_val and a registered rollover_flag. It drives bit_count and the frame_done pulse.

Test Plan:
1. Reset, default params (DATA_BITS=8, PARITY_EN=0) -> packet_data=8'hFF, stop_bit=1, bit_count=0, frame_done=0, both error flags 0.
2. Default params; continuous strobes shifting 1,0,1,0,1,0,1,0 then stop=1 -> packet_data=8'h55, stop_bit=1, frame_done high exactly one cycle after the 9th strobe edge, framing_error=0. Repeat with stop=0 -> framing_error=1 held until the next frame.
3. Strobes with gaps of 0-3 idle cycles between bits of the same frame -> results identical to scenario 2; bit_count holds during gaps.
4. DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0:
   - data 7'b1010011 (4 ones), parity 0, stop 1 -> parity_error=0, frame_done at the 9th strobe.
   - same frame with parity 1 -> parity_error=1.
   - PARITY_ODD=1, data 7'b1010011, parity 1 -> parity_error=0.
5. Clear asserted after 4 strobes, with shift_strobe also high that cycle -> sr all ones, bit_count=0, no frame_done. A following full 9-bit frame completes normally.
6. n_rst pulsed low after 5 strobes -> outputs return to reset values asynchronously, before the next clk edge. A subsequent frame decodes correctly.
